// File: rtl/line_mem_ctrl_if.sv
// Memory-request bus between the write-back cache FSM (master) and the
// backing-memory line controller (slave).
interface line_mem_ctrl_if;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [127:0] read_data;
    logic         ready;
    logic         busy;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  read_data, ready, busy, rd_count, wr_count
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output read_data, ready, busy, rd_count, wr_count
    );
endinterface

// File: rtl/line_mem_ctrl.sv
// Backing-memory line controller: one 128-bit line request at a time,
// completed after a fixed LATENCY and flagged by a one-cycle ready pulse.
module line_mem_ctrl #(
    parameter int IDX_W   = 14,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    line_mem_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                rw_q;
    logic [IDX_W-1:0]    idx_q;
    logic [127:0]        wdata_q;
    logic [127:0]        rdata_q;
    logic                ready_q, busy_q;
    logic [15:0]         rd_cnt_q, wr_cnt_q;
    logic [127:0]        mem_q [DEPTH];

    logic                accept, go_resp, acc_rw;
    logic [IDX_W-1:0]    req_idx, acc_idx;
    logic [127:0]        acc_data;
    logic                unused_addr_bits;

    assign req_idx          = bus.mem_req_addr[IDX_W+3:4];
    assign unused_addr_bits = ^{bus.mem_req_addr[31:IDX_W+4], bus.mem_req_addr[3:0]};

    // Each line starts out holding its own byte addresses; not a reset value.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int w = 0; w < 4; w++) begin
                mem_q[i][32*w +: 32] <= 32'((i * 16 + w * 4) % (1 << (IDX_W + 4)));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        go_resp = 1'b1;
                        state_d = RESP;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 8'(LATENCY);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 8'd1) begin
                    go_resp = 1'b1;
                    state_d = RESP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the array access shares the acceptance edge, so the
    // live request is used directly instead of the latched copy.
    assign acc_rw   = accept ? bus.mem_req_rw   : rw_q;
    assign acc_idx  = accept ? req_idx          : idx_q;
    assign acc_data = accept ? bus.mem_req_data : wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            rw_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == RESP);
            if (accept) begin
                rw_q    <= bus.mem_req_rw;
                idx_q   <= req_idx;
                wdata_q <= bus.mem_req_data;
            end
            if (go_resp) begin
                if (acc_rw) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                    rdata_q  <= mem_q[acc_idx];
                end
            end
        end
    end

    // Gated by rst so a write in flight when reset hits is never committed.
    always_ff @(posedge clk) begin
        if (rst && go_resp && acc_rw) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench for line_mem_ctrl: one instance at LATENCY=4, one at
// LATENCY=1; expected lines come from the address-pattern model plus a shadow.
module tb_line_mem_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    line_mem_ctrl_if bus();
    line_mem_ctrl_if bus1();

    line_mem_ctrl #(.IDX_W(14), .LATENCY(4)) dut  (.clk(clk), .rst(rst_n), .bus(bus));
    line_mem_ctrl #(.IDX_W(14), .LATENCY(1)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

    typedef struct {
        bit           rw;
        logic [13:0]  idx;
        logic [127:0] wdata;
        logic [127:0] exp_rd;
    } txn_t;

    txn_t         exp_q[$];
    logic [127:0] shadow [int];
    logic [127:0] last_rd = '0;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [127:0] model_line(logic [13:0] idx);
        logic [31:0] b;
        b = {14'd0, idx, 4'd0};
        if (shadow.exists(int'(idx))) return shadow[int'(idx)];
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    task automatic drive(input bit sel, input bit v, input bit rw,
                         input logic [31:0] addr, input logic [127:0] data);
        if (sel) begin
            bus1.mem_req_valid = v; bus1.mem_req_rw = rw;
            bus1.mem_req_addr = addr; bus1.mem_req_data = data;
        end else begin
            bus.mem_req_valid = v; bus.mem_req_rw = rw;
            bus.mem_req_addr = addr; bus.mem_req_data = data;
        end
    endtask

    task automatic drop_valid(input bit sel);
        if (sel) bus1.mem_req_valid = 1'b0;
        else     bus.mem_req_valid  = 1'b0;
    endtask

    // Drives one request into an idle controller; the expectation is queued
    // on the acceptance edge.
    task automatic issue(input bit sel, input bit rw, input logic [31:0] addr,
                         input logic [127:0] data, input bit hold);
        txn_t t;
        @(negedge clk);
        drive(sel, 1'b1, rw, addr, data);
        @(posedge clk);
        t.rw     = rw;
        t.idx    = addr[17:4];
        t.wdata  = data;
        t.exp_rd = rw ? last_rd : model_line(addr[17:4]);
        if (!rw) last_rd = t.exp_rd;
        exp_q.push_back(t);
        if (!hold) begin
            #1;
            drop_valid(sel);
        end
    endtask

    // k = number of edges after the acceptance edge before the ready cycle.
    task automatic wait_ready(input bit sel, output int k);
        k = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((sel ? bus1.ready : bus.ready) === 1'b1) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 128'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 128'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.ready, bus.rd_count, bus.wr_count, bus.read_data} !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b ready=%b rd=%0d wr=%0d rdata=%h required all 0",
                     bus.busy, bus.ready, bus.rd_count, bus.wr_count, bus.read_data);
        end
        checks++;
        if ({bus1.busy, bus1.ready, bus1.rd_count, bus1.wr_count, bus1.read_data} !== '0) begin
            errors++;
            $display("FAIL reset_async_lat1: busy=%b ready=%b required 0", bus1.busy, bus1.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.ready} !== 2'b00) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: busy=%b ready=%b required 0 0",
                         c, bus.busy, bus.ready);
            end
        end
    endtask

    task automatic test_read();
        int k;
        txn_t t;
        issue(1'b0, 1'b0, 32'h0001_4024, '0, 1'b0);
        wait_ready(1'b0, k);
        checks++;
        if (k !== 4) begin
            errors++;
            $display("FAIL read_latency: got %0d required 4", k);
        end
        t = exp_q.pop_front();
        checks++;
        if (bus.read_data !== t.exp_rd || bus.read_data !== 128'h0001402C_00014028_00014024_00014020) begin
            errors++;
            $display("FAIL read_data: got %h required %h", bus.read_data, t.exp_rd);
        end
        checks++;
        if (bus.rd_count !== 16'd1) begin
            errors++;
            $display("FAIL read_rd_count: got %0d required 1", bus.rd_count);
        end
        @(negedge clk);
        checks++;
        if ({bus.ready, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL ready_pulse_width: ready=%b busy=%b required 0 0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_write_readback();
        int k;
        txn_t t;
        issue(1'b0, 1'b1, 32'h0001_C024, {4{32'hAAAAAAAA}}, 1'b0);
        wait_ready(1'b0, k);
        t = exp_q.pop_front();
        checks++;
        if (k !== 4 || bus.wr_count !== 16'd1) begin
            errors++;
            $display("FAIL write_done: latency=%0d wr=%0d required 4 1", k, bus.wr_count);
        end
        checks++;
        if (bus.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL write_keeps_rdata: got %h required %h", bus.read_data, t.exp_rd);
        end
        shadow[int'(t.idx)] = t.wdata;
        foreach (t.exp_rd[i]) ; // keeps t referenced uniformly
        issue(1'b0, 1'b0, 32'h0001_C020, '0, 1'b0);
        wait_ready(1'b0, k);
        t = exp_q.pop_front();
        checks++;
        if (k !== 4 || bus.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL readback_written: latency=%0d got %h required %h", k, bus.read_data, t.exp_rd);
        end
        issue(1'b0, 1'b0, 32'h0001_4020, '0, 1'b0);
        wait_ready(1'b0, k);
        t = exp_q.pop_front();
        checks++;
        if (bus.read_data !== t.exp_rd || bus.rd_count !== 16'd3) begin
            errors++;
            $display("FAIL readback_other: got %h rd=%0d required %h 3", bus.read_data, bus.rd_count, t.exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        int   rdy_at[3];
        int   n = 0;
        bit   after_resp = 1'b0;
        txn_t t;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0001_4024, '0);
        for (int i = 0; i < 3; i++) begin
            t.rw = 1'b0; t.idx = 14'h1402; t.wdata = '0; t.exp_rd = model_line(14'h1402);
            last_rd = t.exp_rd;
            exp_q.push_back(t);
        end
        for (int c = 0; c < 40 && (n < 3 || after_resp); c++) begin
            @(negedge clk);
            if (after_resp) begin
                after_resp = 1'b0;
                checks++;
                if ({bus.busy, bus.ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL held_no_accept_in_resp: busy=%b ready=%b required 0 0", bus.busy, bus.ready);
                end
            end
            if (bus.ready === 1'b1) begin
                rdy_at[n] = c;
                t = exp_q.pop_front();
                checks++;
                if (bus.read_data !== t.exp_rd) begin
                    errors++;
                    $display("FAIL held_data %0d: got %h required %h", n, bus.read_data, t.exp_rd);
                end
                n++;
                after_resp = 1'b1;
                if (n == 3) drop_valid(1'b0);
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL held_completions: got %0d required 3", n);
        end else begin
            checks++;
            if (rdy_at[1] - rdy_at[0] !== 6 || rdy_at[2] - rdy_at[1] !== 6) begin
                errors++;
                $display("FAIL held_period: got %0d %0d required 6 6",
                         rdy_at[1] - rdy_at[0], rdy_at[2] - rdy_at[1]);
            end
        end
        checks++;
        if (bus.rd_count !== 16'd6) begin
            errors++;
            $display("FAIL held_rd_count: got %0d required 6", bus.rd_count);
        end
    endtask

    task automatic test_ignored_midflight();
        int k;
        txn_t t;
        issue(1'b0, 1'b0, 32'h0001_4024, '0, 1'b1);
        #2;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, {4{32'hDEADBEEF}});
        wait_ready(1'b0, k);
        drop_valid(1'b0);
        t = exp_q.pop_front();
        checks++;
        if (k !== 4 || bus.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL midflight_read: latency=%0d got %h required %h", k, bus.read_data, t.exp_rd);
        end
        checks++;
        if (bus.rd_count !== 16'd7 || bus.wr_count !== 16'd1) begin
            errors++;
            $display("FAIL midflight_counts: rd=%0d wr=%0d required 7 1", bus.rd_count, bus.wr_count);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_count !== 16'd1) begin
            errors++;
            $display("FAIL midflight_no_reaccept: busy=%b wr=%0d required 0 1", bus.busy, bus.wr_count);
        end
    endtask

    task automatic test_reset_midwrite();
        int k;
        bit saw_ready = 1'b0;
        txn_t t;
        issue(1'b0, 1'b1, 32'h0000_0010, {4{32'h55555555}}, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.ready, bus.rd_count, bus.wr_count, bus.read_data} !== '0) begin
            errors++;
            $display("FAIL reset_midwrite_clear: busy=%b ready=%b rd=%0d wr=%0d rdata=%h required all 0",
                     bus.busy, bus.ready, bus.rd_count, bus.wr_count, bus.read_data);
        end
        exp_q.delete();
        last_rd = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) saw_ready = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready) begin
            errors++;
            $display("FAIL reset_midwrite_ready: got a ready pulse required none");
        end
        issue(1'b0, 1'b0, 32'h0000_0010, '0, 1'b0);
        wait_ready(1'b0, k);
        t = exp_q.pop_front();
        checks++;
        if (k !== 4 || bus.read_data !== t.exp_rd || bus.read_data !== 128'h0000001C_00000018_00000014_00000010) begin
            errors++;
            $display("FAIL reset_midwrite_untouched: latency=%0d got %h required %h", k, bus.read_data, t.exp_rd);
        end
        checks++;
        if (bus.rd_count !== 16'd1 || bus.wr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_midwrite_counts: rd=%0d wr=%0d required 1 0", bus.rd_count, bus.wr_count);
        end
    endtask

    task automatic test_latency1();
        int k;
        txn_t t;
        shadow.delete();
        last_rd = '0;
        issue(1'b1, 1'b0, 32'h0000_0010, '0, 1'b0);
        wait_ready(1'b1, k);
        t = exp_q.pop_front();
        checks++;
        if (k !== 0 || bus1.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL lat1_read: latency=%0d got %h required 0 %h", k, bus1.read_data, t.exp_rd);
        end
        issue(1'b1, 1'b1, 32'h0000_0020, {4{32'h12345678}}, 1'b0);
        wait_ready(1'b1, k);
        t = exp_q.pop_front();
        shadow[int'(t.idx)] = t.wdata;
        checks++;
        if (k !== 0 || bus1.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL lat1_write: latency=%0d rdata=%h required 0 %h", k, bus1.read_data, t.exp_rd);
        end
        issue(1'b1, 1'b0, 32'h0000_0028, '0, 1'b0);
        wait_ready(1'b1, k);
        t = exp_q.pop_front();
        checks++;
        if (k !== 0 || bus1.read_data !== t.exp_rd) begin
            errors++;
            $display("FAIL lat1_readback: latency=%0d got %h required %h", k, bus1.read_data, t.exp_rd);
        end
        checks++;
        if (bus1.rd_count !== 16'd2 || bus1.wr_count !== 16'd1) begin
            errors++;
            $display("FAIL lat1_counts: rd=%0d wr=%0d required 2 1", bus1.rd_count, bus1.wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_readback();
        test_back_to_back();
        test_ignored_midflight();
        test_reset_midwrite();
        test_latency1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
